// File: rtl/zap_frame_seq_pkg.sv
// zap_frame_seq_pkg: state encoding, settle default and enabled-target picker
package zap_frame_seq_pkg;
  localparam int SETTLE_LINES_DEF = 16;
  typedef enum logic [2:0] {IDLE, ARM, BLANK, TARGET, DONE, RELEASE} state_t;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;
  function automatic pick_t next_enabled(input logic [7:0] mask, input logic [3:0] from);
    pick_t p;
    p = '0;
    for (int i = 7; i >= 0; i--)
      if (mask[i] && 4'(i) >= from) p = '{found: 1'b1, idx: 3'(i)};
    return p;
  endfunction
endpackage

// File: rtl/zap_line_settle.sv
// zap_line_settle: frame-reset saturating line counter gating photodiode sampling
module zap_line_settle import zap_frame_seq_pkg::*; #(
  parameter int SETTLE_LINES = SETTLE_LINES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic line_start,
  output logic sample_ok
);
  localparam int CW = $clog2(SETTLE_LINES + 2);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (frame_start) cnt <= '0;
    else if (line_start && cnt != CW'(SETTLE_LINES)) cnt <= cnt + CW'(1);
  end
  assign sample_ok = cnt == CW'(SETTLE_LINES);
endmodule

// File: rtl/zap_frame_seq.sv
// zap_frame_seq: frame-aligned light-gun measurement sequencer (black, then one frame per target)
module zap_frame_seq import zap_frame_seq_pkg::*; #(
  parameter int NUM_TARGETS  = 4,
  parameter int TGT_W        = 3,
  parameter int BLANK_FRAMES = 1,
  parameter int SETTLE_LINES = SETTLE_LINES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   line_start,
  input  logic                   shot,
  input  logic                   hit,
  input  logic [NUM_TARGETS-1:0] target_en,
  output logic                   flash_black,
  output logic                   flash_target,
  output logic [TGT_W-1:0]       target_sel,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   result_hit,
  output logic [TGT_W-1:0]       result_idx,
  output logic                   result_cheat,
  input  logic                   result_ack
);
  state_t                 state;
  logic                   shot_q, sample_ok, cheat, hit_f;
  logic [3:0]             frame_cnt;
  logic [NUM_TARGETS-1:0] mask;
  logic [TGT_W-1:0]       hit_idx;
  pick_t                  first, next;
  logic                   shot_rise, new_hit, found;
  zap_line_settle #(.SETTLE_LINES(SETTLE_LINES)) u_settle (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start), .sample_ok(sample_ok)
  );
  assign shot_rise = shot & ~shot_q;
  assign new_hit   = sample_ok & hit & ~cheat & ~hit_f;
  // a hit coinciding with frame_start still belongs to the ending frame
  assign found     = hit_f | new_hit;
  assign first     = next_enabled(8'(mask), 4'd0);
  assign next      = next_enabled(8'(mask), 4'(target_sel) + 4'd1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shot_q       <= 1'b0;
      cheat        <= 1'b0;
      hit_f        <= 1'b0;
      frame_cnt    <= '0;
      mask         <= '0;
      hit_idx      <= '0;
      flash_black  <= 1'b0;
      flash_target <= 1'b0;
      target_sel   <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      result_idx   <= '0;
      result_cheat <= 1'b0;
    end else begin
      shot_q <= shot;
      case (state)
        IDLE: if (shot_rise) begin
          if (|target_en) begin
            mask  <= target_en;
            cheat <= 1'b0;
            hit_f <= 1'b0;
            busy  <= 1'b1;
            state <= ARM;
          end else begin
            result_valid <= 1'b1;
            result_hit   <= 1'b0;
            result_idx   <= '0;
            result_cheat <= 1'b0;
            state        <= DONE;
          end
        end
        ARM: if (frame_start) begin
          frame_cnt   <= 4'(BLANK_FRAMES - 1);
          flash_black <= 1'b1;
          state       <= BLANK;
        end
        BLANK: begin
          if (sample_ok && hit) cheat <= 1'b1;
          if (frame_start) begin
            if (frame_cnt == 4'd0) begin
              flash_black  <= 1'b0;
              flash_target <= first.found;
              target_sel   <= TGT_W'(first.idx);
              state        <= TARGET;
            end else frame_cnt <= frame_cnt - 4'd1;
          end
        end
        TARGET: begin
          if (new_hit) begin
            hit_f   <= 1'b1;
            hit_idx <= target_sel;
          end
          if (frame_start) begin
            if (found || !next.found) begin
              flash_target <= 1'b0;
              busy         <= 1'b0;
              result_valid <= 1'b1;
              result_hit   <= found & ~cheat;
              result_idx   <= (found && !cheat) ? (new_hit ? target_sel : hit_idx) : '0;
              result_cheat <= cheat;
              state        <= DONE;
            end else target_sel <= TGT_W'(next.idx);
          end
        end
        DONE: if (result_ack) begin
          result_valid <= 1'b0;
          state        <= RELEASE;
        end
        RELEASE: if (!shot) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zap_frame_seq.sv
// tb_zap_frame_seq: directed and randomized shots checked against a frame-level result model
module tb_zap_frame_seq;
  localparam int NT = 4, TW = 3, BF = 1, SL = 16, LINES = 48, LCYC = 4;
  logic clk = 1'b0, rst = 1'b0, frame_start = 1'b0, line_start = 1'b0;
  logic shot = 1'b0, hit = 1'b0, result_ack = 1'b0;
  logic [NT-1:0] target_en = '0;
  logic flash_black, flash_target, busy, result_valid, result_hit, result_cheat;
  logic [TW-1:0] target_sel, result_idx;
  int checks = 0, errors = 0;
  int line = 0, cyc = 0, rel = 0;
  int hlo[0:15], hhi[0:15];
  always #5 clk = ~clk;
  zap_frame_seq #(.NUM_TARGETS(NT), .TGT_W(TW), .BLANK_FRAMES(BF), .SETTLE_LINES(SL)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .shot(shot), .hit(hit), .target_en(target_en),
    .flash_black(flash_black), .flash_target(flash_target), .target_sel(target_sel),
    .busy(busy), .result_valid(result_valid), .result_hit(result_hit),
    .result_idx(result_idx), .result_cheat(result_cheat), .result_ack(result_ack)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // video timing: frame_start coincides with line 0's line_start; hit never on a line's first cycle
  task automatic step();
    @(posedge clk); #1;
    cyc = (cyc == LCYC - 1) ? 0 : cyc + 1;
    if (cyc == 0) line = (line == LINES - 1) ? 0 : line + 1;
    frame_start = (line == 0 && cyc == 0);
    line_start = (cyc == 0);
    if (frame_start) rel++;
    hit = (rel < 16) ? (cyc != 0 && line >= hlo[rel] && line <= hhi[rel]) : 1'b0;
  endtask
  function automatic bit hit_in(input int f);
    return f < 16 && hhi[f] >= SL && hlo[f] <= hhi[f];
  endfunction
  task automatic clear_plan();
    for (int f = 0; f < 16; f++) begin
      hlo[f] = 1000;
      hhi[f] = -1;
    end
  endtask
  task automatic rise(input logic [NT-1:0] mask);
    shot = 1'b0;
    step();
    step();
    while (line < 2 || line > LINES - 4) step();
    target_en = mask;
    shot = 1'b1;
    rel = 0;
  endtask
  task automatic run_shot(input logic [NT-1:0] mask, input int ack_delay, input bit hold_shot);
    int order[$];
    int flast, exp_idx;
    bit exp_hit, exp_cheat;
    for (int i = 0; i < NT; i++) if (mask[i]) order.push_back(i);
    exp_cheat = 1'b0;
    for (int f = 1; f <= BF; f++) if (hit_in(f)) exp_cheat = 1'b1;
    exp_hit = 1'b0;
    exp_idx = 0;
    flast = BF + order.size();
    if (!exp_cheat)
      for (int k = 0; k < order.size(); k++)
        if (!exp_hit && hit_in(BF + 1 + k)) begin
          exp_hit = 1'b1;
          exp_idx = order[k];
          flast = BF + 1 + k;
        end
    rise(mask);
    while (rel <= flast) begin
      step();
      if (line == 30 && cyc == 2 && rel >= 1) begin
        chk("busy_seq", busy, 1);
        if (rel <= BF) begin
          chk("black_on", flash_black, 1);
          chk("black_tgt_off", flash_target, 0);
        end else begin
          chk("tgt_on", flash_target, 1);
          chk("tgt_black_off", flash_black, 0);
          chk("tgt_sel", target_sel, order[rel-BF-1]);
        end
      end
      result_ack = (rel >= 1 && line >= 5 && line <= 40 && $urandom_range(0, 99) < 5);
      if (rel >= 1 && $urandom_range(0, 99) < 2) target_en = NT'($urandom);
      if (rel >= 1 && line > 3 && $urandom_range(0, 299) == 0) shot = ~shot;
    end
    result_ack = 1'b0;
    chk("valid_early", result_valid, 0);
    step();
    chk("valid_rise", result_valid, 1);
    chk("done_black", flash_black, 0);
    chk("done_tgt", flash_target, 0);
    chk("done_busy", busy, 0);
    chk("res_hit", result_hit, exp_hit);
    chk("res_idx", result_idx, exp_idx);
    chk("res_cheat", result_cheat, exp_cheat);
    for (int d = 0; d < ack_delay; d++) begin
      step();
      chk("valid_hold", result_valid, 1);
      chk("idx_hold", result_idx, exp_idx);
    end
    shot = hold_shot ? 1'b1 : shot;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    chk("valid_drop", result_valid, 0);
    if (hold_shot) begin
      repeat (LINES * LCYC) step();
      chk("rearm_busy", busy, 0);
      chk("rearm_valid", result_valid, 0);
      chk("rearm_black", flash_black, 0);
    end
    shot = 1'b0;
    repeat (3) step();
  endtask
  initial begin
    logic [NT-1:0] m;
    clear_plan();
    repeat (3) step();
    chk("rst_black", flash_black, 0);
    chk("rst_tgt", flash_target, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_sel", target_sel, 0);
    rst = 1'b1;
    repeat (3) step();
    hlo[3] = 40;
    hhi[3] = 40;
    run_shot(4'b0101, 0, 1'b0);
    clear_plan();
    run_shot(4'b1111, 4, 1'b0);
    hlo[1] = 20;
    hhi[1] = 20;
    hlo[2] = 30;
    hhi[2] = 35;
    run_shot(4'b0011, 1, 1'b0);
    for (int f = 0; f < 16; f++) begin
      hlo[f] = 0;
      hhi[f] = SL - 1;
    end
    run_shot(4'b1010, 2, 1'b1);
    clear_plan();
    rise(4'b1111);
    while (!(rel == BF + 2 && line == 10) && rel < 8) step();
    chk("pre_abort_tgt", flash_target, 1);
    rst = 1'b0;
    #1;
    chk("abort_tgt", flash_target, 0);
    chk("abort_busy", busy, 0);
    chk("abort_black", flash_black, 0);
    shot = 1'b0;
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("post_abort_busy", busy, 0);
    rise('0);
    step();
    chk("empty_valid", result_valid, 1);
    chk("empty_hit", result_hit, 0);
    chk("empty_busy", busy, 0);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    chk("empty_drop", result_valid, 0);
    shot = 1'b0;
    repeat (3) step();
    for (int t = 0; t < 12; t++) begin
      clear_plan();
      for (int f = 1; f < 8; f++)
        if ($urandom_range(0, 99) < 35) begin
          hlo[f] = $urandom_range(0, LINES - 1);
          hhi[f] = $urandom_range(hlo[f], LINES - 1);
        end
      m = NT'($urandom_range(1, (1 << NT) - 1));
      run_shot(m, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
